ysyx_22040237_lsu: RTL
======================

Name: ysyx_22040237_lsu

Overview:
Load/store stage directly downstream of the execute unit. It consumes the ALU result, the 7-bit LS info bus and the store data. For ALU and jump instructions it registers the result toward write-back. For loads and stores it runs a multi-cycle request/ack transaction on a 64-bit data-memory port, lane-aligning stores and sign- or zero-extending loads. It stalls upstream while a transaction is outstanding.

Parameters:
XLEN, 64, register/data width (only 64 supported)
TIMEOUT, 255, maximum cycles waiting for mem_ack_i before an access error (8-bit counter)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous reset, active-low
valid_i  in  1  EXU output valid this cycle
ready_o  out  1  LSU can accept; high only in IDLE
rd_wr_en_i  in  1  writeback enable from EXU
rd_idx_i  in  5  destination register
alu_res_i  in  XLEN  ALU result, or effective address for load/store
ls_info_bus_i  in  7  {dw, word, half(db), byte, usign, store, load}, bit0 = load
rs2_store_i  in  XLEN  store data (low bits significant)
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  XLEN  8-byte-aligned address (addr[2:0] forced to 0)
mem_wdata_o  out  XLEN  lane-shifted store data
mem_wmask_o  out  8  byte write strobes
mem_ack_i  in  1  memory completes request; rdata valid same cycle
mem_rdata_i  in  XLEN  read data
wb_valid_o  out  1  one-cycle pulse, result presented to WB
rd_wr_en_o  out  1  WB enable (qualified by wb_valid_o)
rd_idx_o  out  5  WB register index
wb_data_o  out  XLEN  WB data
lsu_err_o  out  1  one-cycle pulse: misaligned, malformed, or timed-out access

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, timeout counter 0. Reset mid-transaction drops mem_req_o immediately. No WB pulse follows.
- States: IDLE, MEM, DONE.
- IDLE, valid_i=1, load=store=0: capture rd_wr_en/rd_idx/alu_res. Next cycle wb_valid_o=1 and wb_data_o=alu_res_i (latency 1), then stay in IDLE. ready_o stays 1, so back-to-back pass-through runs at full rate.
- IDLE, valid_i=1, load^store: decode and check the access.
  - Size must be exactly one of byte/half/word/dw.
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=0; dw requires addr[2:0]=0.
  - If the check fails, or load and store are both set: no memory request. Next cycle lsu_err_o=1 and wb_valid_o=1 with rd_wr_en_o=0.
  - Otherwise go to MEM. Register mem_req_o=1 with addr, we, wmask and wdata, stable until ack.
- wmask/wdata, with off=addr[2:0]:
  - byte: 8'h01<<off
  - half: 8'h03<<off
  - word: 8'h0F<<off
  - dw: 8'hFF
  - mem_wdata_o = rs2_store_i << (8*off)
  - Loads drive wmask 0 and wdata 0.
- MEM:
  - On mem_ack_i=1: deassert req. For loads, latch (mem_rdata_i >> 8*off) truncated to size, then sign-extended, or zero-extended if usign. Go to DONE.
  - Counter increments each MEM cycle without ack. At count==TIMEOUT: drop req, pulse lsu_err_o, go to DONE with rd_wr_en_o=0.
- DONE (one cycle): wb_valid_o=1.
  - Loads: rd_wr_en_o = rd_wr_en_i captured.
  - Stores: rd_wr_en_o=0.
  - Then IDLE, counter cleared.
- ready_o=0 in MEM and DONE. Upstream holds its inputs; valid_i is ignored outside IDLE.
- mem_ack_i outside MEM is ignored.
- Ack in the same cycle the counter hits TIMEOUT: ack wins, no error.
- wb_valid_o, lsu_err_o and all WB outputs are registered. WB outputs hold their last values when wb_valid_o=0.

Decomposition:
- Shared package/defines: LS bus bit indices (LOAD=0, STORE=1, USIGN=2, BYTE=3, HALF=4, WORD=5, DW=6), state encodings, size codes.
- One sub-module, ysyx_22040237_lsu_align (combinational): address offset, size and data in → wmask, shifted wdata, extracted/extended load data, misalign flag.

Test Plan:
- ALU pass-through: valid_i with alu_res=0x1234, rd=5, wr_en=1 → next cycle wb_valid_o=1, wb_data_o=0x1234, rd_idx_o=5. Back-to-back issue gives two consecutive pulses.
- Signed byte load: addr 0x8000_0003, mem_rdata=0x0000_0000_8000_0000 (lane 3 = 0x80), ack after 3 cycles → wb_data_o=0xFFFF_FFFF_FFFF_FF80. With usign set → 0x80.
- Half store: addr 0x8000_0006, rs2=0xABCD → mem_addr_o=0x8000_0000, wmask=0xC0, wdata=0xABCD_0000_0000_0000, we=1. WB pulse has rd_wr_en_o=0.
- Misaligned word load: addr 0x8000_0002 → no mem_req_o. Next cycle lsu_err_o=1, wb_valid_o=1, rd_wr_en_o=0.
- Timeout: never ack → req held exactly 255 cycles, then lsu_err_o pulse and return to IDLE. A separate case with ack on cycle 255 → normal completion, no error.
- Reset mid-MEM: drop rst during an outstanding req → mem_req_o=0 asynchronously. No wb_valid_o after release, ready_o=1.

Source files
------------

// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: LS info bus layout, FSM states and size codes.
package ysyx_22040237_lsu_pkg;

  // Bit positions on the 7-bit LS info bus
  localparam int unsigned LsLoad  = 0;
  localparam int unsigned LsStore = 1;
  localparam int unsigned LsUsign = 2;
  localparam int unsigned LsByte  = 3;
  localparam int unsigned LsHalf  = 4;
  localparam int unsigned LsWord  = 5;
  localparam int unsigned LsDw    = 6;

  // One-hot size codes, taken directly from ls_info_bus[6:3]
  localparam logic [3:0] SzByte = 4'b0001;
  localparam logic [3:0] SzHalf = 4'b0010;
  localparam logic [3:0] SzWord = 4'b0100;
  localparam logic [3:0] SzDw   = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Lane alignment: store strobes/data shift, load extraction/extension and access checking.
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      off,
  input  logic [3:0]      size,
  input  logic            usign,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            bad
);

  logic [5:0]      sh_amt;
  logic [XLEN-1:0] rsh;

  assign sh_amt = {off, 3'b000};
  assign rsh    = rdata >> sh_amt;
  assign wdata  = store_data << sh_amt;

  // bad covers both a malformed size field (not exactly one-hot) and misalignment
  always_comb begin
    wmask     = 8'h00;
    load_data = rsh;
    bad       = 1'b1;
    case (size)
      SzByte: begin
        wmask     = 8'h01 << off;
        load_data = usign ? {{(XLEN-8){1'b0}}, rsh[7:0]} : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
        bad       = 1'b0;
      end
      SzHalf: begin
        wmask     = 8'h03 << off;
        load_data = usign ? {{(XLEN-16){1'b0}}, rsh[15:0]} : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
        bad       = off[0];
      end
      SzWord: begin
        wmask     = 8'h0F << off;
        load_data = usign ? {{(XLEN-32){1'b0}}, rsh[31:0]} : {{(XLEN-32){rsh[31]}}, rsh[31:0]};
        bad       = |off[1:0];
      end
      SzDw: begin
        wmask     = 8'hFF;
        load_data = rsh;
        bad       = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store stage: registers ALU results to WB and runs req/ack data-memory transactions.
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [6:0]      ls_info_bus_i,
  input  logic [XLEN-1:0] rs2_store_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wmask_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic            rd_wr_en_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            lsu_err_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  lsu_state_e state_q;
  logic [7:0] cnt_q;
  logic [2:0] off_q;
  logic [3:0] size_q;
  logic       usign_q;
  logic       is_load_q;
  logic       wr_en_q;
  logic [4:0] rd_idx_q;

  logic            is_load;
  logic            is_store;
  logic            use_live;
  logic [2:0]      al_off;
  logic [3:0]      al_size;
  logic            al_usign;
  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load_data;
  logic            al_bad;

  assign is_load  = ls_info_bus_i[LsLoad];
  assign is_store = ls_info_bus_i[LsStore];
  assign ready_o  = (state_q == StIdle);

  // In IDLE the aligner sees the incoming request; in MEM it sees the latched access
  assign use_live = (state_q == StIdle);
  assign al_off   = use_live ? alu_res_i[2:0] : off_q;
  assign al_size  = use_live ? ls_info_bus_i[LsDw:LsByte] : size_q;
  assign al_usign = use_live ? ls_info_bus_i[LsUsign] : usign_q;

  ysyx_22040237_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off       (al_off),
    .size      (al_size),
    .usign     (al_usign),
    .store_data(rs2_store_i),
    .rdata     (mem_rdata_i),
    .wmask     (al_wmask),
    .wdata     (al_wdata),
    .load_data (al_load_data),
    .bad       (al_bad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      off_q       <= 3'd0;
      size_q      <= 4'd0;
      usign_q     <= 1'b0;
      is_load_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_idx_q    <= 5'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= 8'h00;
      wb_valid_o  <= 1'b0;
      rd_wr_en_o  <= 1'b0;
      rd_idx_o    <= 5'd0;
      wb_data_o   <= '0;
      lsu_err_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (!is_load && !is_store) begin
              wb_valid_o <= 1'b1;
              rd_wr_en_o <= rd_wr_en_i;
              rd_idx_o   <= rd_idx_i;
              wb_data_o  <= alu_res_i;
            end else if ((is_load && is_store) || al_bad) begin
              wb_valid_o <= 1'b1;
              lsu_err_o  <= 1'b1;
              rd_wr_en_o <= 1'b0;
              rd_idx_o   <= rd_idx_i;
            end else begin
              state_q     <= StMem;
              cnt_q       <= 8'd0;
              off_q       <= alu_res_i[2:0];
              size_q      <= ls_info_bus_i[LsDw:LsByte];
              usign_q     <= ls_info_bus_i[LsUsign];
              is_load_q   <= is_load;
              wr_en_q     <= rd_wr_en_i;
              rd_idx_q    <= rd_idx_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store;
              mem_addr_o  <= {alu_res_i[XLEN-1:3], 3'b000};
              mem_wmask_o <= is_store ? al_wmask : 8'h00;
              mem_wdata_o <= is_store ? al_wdata : '0;
            end
          end
        end
        StMem: begin
          // Ack takes priority over a timeout in the same cycle
          if (mem_ack_i) begin
            state_q    <= StDone;
            mem_req_o  <= 1'b0;
            wb_valid_o <= 1'b1;
            rd_wr_en_o <= is_load_q & wr_en_q;
            rd_idx_o   <= rd_idx_q;
            if (is_load_q) begin
              wb_data_o <= al_load_data;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_q    <= StDone;
            cnt_q      <= cnt_q + 8'd1;
            mem_req_o  <= 1'b0;
            wb_valid_o <= 1'b1;
            lsu_err_o  <= 1'b1;
            rd_wr_en_o <= 1'b0;
            rd_idx_o   <= rd_idx_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= 8'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
